// File: rtl/motor_pkg.sv
// Shared types, constants and default parameters for the drive-motor
// ramp sequencer and its per-wheel channel block.
package motor_pkg;

    // Per-channel sequencing states.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        RAMP_DOWN = 2'd1,
        DEAD      = 2'd2
    } ch_state_e;

    // H-bridge direction levels.
    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Default parameter values.
    localparam int DUTY_W_DEF      = 8;
    localparam int RAMP_DIV_DEF    = 16;
    localparam int RAMP_STEP_DEF   = 8;
    localparam int DEAD_CYCLES_DEF = 32;

    // True when a requested direction differs from the applied one.
    function automatic logic dir_flip(input logic cur_dir, input logic req_dir);
        return (cur_dir != req_dir);
    endfunction

endpackage

// File: rtl/motor_channel_ramp.sv
// One wheel channel: holds target/applied duty, slews applied toward target
// on ramp ticks, sequences reversals through ramp-down and dead time, and
// compares the shared PWM counter against a period-aligned compare value.
module motor_channel_ramp
    import motor_pkg::*;
#(
    parameter int DUTY_W      = DUTY_W_DEF,
    parameter int RAMP_STEP   = RAMP_STEP_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              period_end,
    input  logic [DUTY_W-1:0] counter,
    input  logic              stop,
    input  logic              accept,
    input  logic              cmd_dir,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              pwm,
    output logic              dir,
    output logic              run,
    output logic              at_target
);

    localparam int                DEAD_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] STEP_C    = DUTY_W'(RAMP_STEP);

    ch_state_e          state_r;
    logic               dir_r;
    logic [DUTY_W-1:0]  target_r;
    logic [DUTY_W-1:0]  applied_r;
    logic [DUTY_W-1:0]  cmp_r;
    logic               pend_dir_r;
    logic [DUTY_W-1:0]  pend_duty_r;
    logic [DEAD_W-1:0]  dead_cnt_r;

    logic               rev_accept_s;
    logic [DUTY_W-1:0]  goal_s;
    logic [DUTY_W-1:0]  diff_s;
    logic [DUTY_W-1:0]  delta_s;
    logic [DUTY_W-1:0]  ramped_s;
    logic               pwm_s;

    // Slew-limited next applied duty; a reversing accept ramps toward zero at once.
    always_comb begin
        rev_accept_s = (state_r == RUN) && accept && dir_flip(dir_r, cmd_dir);
        if (rev_accept_s) begin
            goal_s = '0;
        end else begin
            goal_s = target_r;
        end
        if (goal_s >= applied_r) begin
            diff_s = goal_s - applied_r;
        end else begin
            diff_s = applied_r - goal_s;
        end
        if (32'(diff_s) > 32'(RAMP_STEP)) begin
            delta_s = STEP_C;
        end else begin
            delta_s = diff_s;
        end
        if (!tick) begin
            ramped_s = applied_r;
        end else if (goal_s >= applied_r) begin
            ramped_s = applied_r + delta_s;
        end else begin
            ramped_s = applied_r - delta_s;
        end
    end

    // PWM compare; held low during emergency stop and dead time.
    always_comb begin
        if (stop || (state_r == DEAD)) begin
            pwm_s = 1'b0;
        end else begin
            pwm_s = (counter < cmp_r);
        end
    end

    // Channel sequencing: retarget, reversal ramp-down, dead time, stop clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= RUN;
            dir_r       <= DIR_FWD;
            target_r    <= '0;
            applied_r   <= '0;
            cmp_r       <= '0;
            pend_dir_r  <= DIR_REV;
            pend_duty_r <= '0;
            dead_cnt_r  <= '0;
        end else if (stop) begin
            state_r     <= RUN;
            target_r    <= '0;
            applied_r   <= '0;
            cmp_r       <= '0;
            pend_dir_r  <= DIR_REV;
            pend_duty_r <= '0;
            dead_cnt_r  <= '0;
        end else begin
            applied_r <= ramped_s;
            if (period_end) begin
                cmp_r <= applied_r;
            end
            case (state_r)
                RUN: begin
                    if (rev_accept_s) begin
                        pend_dir_r  <= cmd_dir;
                        pend_duty_r <= cmd_duty;
                        target_r    <= '0;
                        dead_cnt_r  <= '0;
                        if ((applied_r == '0) && (cmp_r == '0)) begin
                            state_r <= DEAD;
                        end else begin
                            state_r <= RAMP_DOWN;
                        end
                    end else if (accept) begin
                        target_r <= cmd_duty;
                    end
                end
                RAMP_DOWN: begin
                    // Wait for zero duty and a zero compare so the bridge is truly idle.
                    if ((applied_r == '0) && (cmp_r == '0)) begin
                        state_r    <= DEAD;
                        dead_cnt_r <= '0;
                    end
                end
                DEAD: begin
                    if (dead_cnt_r == DEAD_LAST) begin
                        dir_r      <= pend_dir_r;
                        target_r   <= pend_duty_r;
                        state_r    <= RUN;
                        dead_cnt_r <= '0;
                    end else begin
                        dead_cnt_r <= dead_cnt_r + DEAD_W'(1);
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    assign pwm       = pwm_s;
    assign dir       = dir_r;
    assign run       = (state_r == RUN);
    assign at_target = (applied_r == target_r);

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Two-wheel motor sequencer: shared PWM period counter, ramp tick divider,
// command handshake and settled flag around two channel instances.
module motor_ramp_sequencer
    import motor_pkg::*;
#(
    parameter int DUTY_W      = DUTY_W_DEF,
    parameter int RAMP_DIV    = RAMP_DIV_DEF,
    parameter int RAMP_STEP   = RAMP_STEP_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir_l,
    input  logic              cmd_dir_r,
    input  logic [DUTY_W-1:0] cmd_duty_l,
    input  logic [DUTY_W-1:0] cmd_duty_r,
    input  logic              stop_req,
    output logic              motorL_pwm,
    output logic              motorR_pwm,
    output logic              motorL_dir,
    output logic              motorR_dir,
    output logic              settled
);

    localparam int                TICK_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);

    logic [DUTY_W-1:0] pwm_cnt_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              settled_r;

    logic              tick_s;
    logic              period_end_s;
    logic              ready_s;
    logic              accept_s;
    logic              run_l_s;
    logic              run_r_s;
    logic              at_l_s;
    logic              at_r_s;

    // Free-running PWM period counter, wraps at the top of the range.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + DUTY_W'(1);
        end
    end

    // Ramp tick divider, one tick per RAMP_DIV cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_r <= '0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Strobes and handshake; stop always wins over a pending command.
    always_comb begin
        tick_s       = (tick_cnt_r == TICK_LAST);
        period_end_s = (pwm_cnt_r == '1);
        ready_s      = !stop_req && run_l_s && run_r_s;
        accept_s     = cmd_valid && ready_s;
    end

    // Settled flag: both channels running and at their targets.
    always_ff @(posedge clk) begin
        if (!reset) begin
            settled_r <= 1'b1;
        end else begin
            settled_r <= run_l_s && run_r_s && at_l_s && at_r_s;
        end
    end

    assign cmd_ready = ready_s;
    assign settled   = settled_r;

    motor_channel_ramp #(
        .DUTY_W      (DUTY_W),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch_l (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick_s),
        .period_end (period_end_s),
        .counter    (pwm_cnt_r),
        .stop       (stop_req),
        .accept     (accept_s),
        .cmd_dir    (cmd_dir_l),
        .cmd_duty   (cmd_duty_l),
        .pwm        (motorL_pwm),
        .dir        (motorL_dir),
        .run        (run_l_s),
        .at_target  (at_l_s)
    );

    motor_channel_ramp #(
        .DUTY_W      (DUTY_W),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch_r (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick_s),
        .period_end (period_end_s),
        .counter    (pwm_cnt_r),
        .stop       (stop_req),
        .accept     (accept_s),
        .cmd_dir    (cmd_dir_r),
        .cmd_duty   (cmd_duty_r),
        .pwm        (motorR_pwm),
        .dir        (motorR_dir),
        .run        (run_r_s),
        .at_target  (at_r_s)
    );

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Bench for motor_ramp_sequencer: directed scenarios followed by random
// commands and stop pulses, every cycle compared against a behavioural model
// of the wheel sequencing rules.
module tb_motor_ramp_sequencer;

    localparam int DIV  = 16;
    localparam int STEP = 8;
    localparam int DT   = 32;
    localparam int PER  = 256;

    localparam int M_RUN  = 0;
    localparam int M_DOWN = 1;
    localparam int M_DEAD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir_l = 1'b1;
    logic       cmd_dir_r = 1'b1;
    logic [7:0] cmd_duty_l = 8'd0;
    logic [7:0] cmd_duty_r = 8'd0;
    logic       stop_req = 1'b0;
    logic       cmd_ready;
    logic       motorL_pwm;
    logic       motorR_pwm;
    logic       motorL_dir;
    logic       motorR_dir;
    logic       settled;

    int checks = 0;
    int failures = 0;
    int hi_l = 0;
    int hi_r = 0;

    // Model state: period position, tick phase and per-wheel quantities.
    int pc, tc, set_m;
    int st[2], dr[2], tg[2], ap[2], pdir[2], pduty[2], dc[2], cm[2];

    motor_ramp_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir_l  (cmd_dir_l),
        .cmd_dir_r  (cmd_dir_r),
        .cmd_duty_l (cmd_duty_l),
        .cmd_duty_r (cmd_duty_r),
        .stop_req   (stop_req),
        .motorL_pwm (motorL_pwm),
        .motorR_pwm (motorR_pwm),
        .motorL_dir (motorL_dir),
        .motorR_dir (motorR_dir),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int toward(input int a, input int g);
        if (g > a) return a + (((g - a) < STEP) ? (g - a) : STEP);
        else       return a - (((a - g) < STEP) ? (a - g) : STEP);
    endfunction

    function automatic int m_ready();
        return (!stop_req && st[0] == M_RUN && st[1] == M_RUN) ? 1 : 0;
    endfunction

    function automatic int m_pwm(input int c);
        return (!stop_req && st[c] != M_DEAD && pc < cm[c]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        pc = 0; tc = 0; set_m = 1;
        for (int c = 0; c < 2; c++) begin
            st[c] = M_RUN; dr[c] = 1; tg[c] = 0; ap[c] = 0;
            pdir[c] = 0; pduty[c] = 0; dc[c] = 0; cm[c] = 0;
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_clock();
        int acc, tick, pend, nset, goal, oap, ocm;
        int cd[2];
        int cu[2];
        if (!reset) begin
            model_reset();
            return;
        end
        acc  = (cmd_valid && m_ready() == 1) ? 1 : 0;
        tick = (tc == DIV - 1) ? 1 : 0;
        pend = (pc == PER - 1) ? 1 : 0;
        nset = (st[0] == M_RUN && st[1] == M_RUN && ap[0] == tg[0] && ap[1] == tg[1]) ? 1 : 0;
        cd[0] = int'(cmd_dir_l);  cd[1] = int'(cmd_dir_r);
        cu[0] = int'(cmd_duty_l); cu[1] = int'(cmd_duty_r);
        for (int c = 0; c < 2; c++) begin
            if (stop_req) begin
                ap[c] = 0; cm[c] = 0; tg[c] = 0; pduty[c] = 0; pdir[c] = 0;
                st[c] = M_RUN; dc[c] = 0;
            end else begin
                oap = ap[c]; ocm = cm[c]; goal = tg[c];
                if (st[c] == M_RUN && acc == 1 && cd[c] != dr[c]) goal = 0;
                if (st[c] == M_RUN) begin
                    if (acc == 1 && cd[c] == dr[c]) tg[c] = cu[c];
                    else if (acc == 1) begin
                        pdir[c] = cd[c]; pduty[c] = cu[c]; tg[c] = 0; dc[c] = 0;
                        st[c] = (oap == 0 && ocm == 0) ? M_DEAD : M_DOWN;
                    end
                end else if (st[c] == M_DOWN) begin
                    if (oap == 0 && ocm == 0) begin st[c] = M_DEAD; dc[c] = 0; end
                end else begin
                    if (dc[c] == DT - 1) begin
                        dr[c] = pdir[c]; tg[c] = pduty[c]; st[c] = M_RUN; dc[c] = 0;
                    end else dc[c]++;
                end
                if (tick == 1) ap[c] = toward(oap, goal);
                if (pend == 1) cm[c] = oap;
            end
        end
        set_m = nset;
        pc = (pc + 1) % PER;
        tc = (tc + 1) % DIV;
    endtask

    // Compare all outputs against the model, then cross one clock edge.
    task automatic step();
        #1;
        chk("cmd_ready", cmd_ready, m_ready());
        chk("pwm_l", motorL_pwm, m_pwm(0));
        chk("pwm_r", motorR_pwm, m_pwm(1));
        chk("dir_l", motorL_dir, dr[0]);
        chk("dir_r", motorR_dir, dr[1]);
        chk("settled", settled, set_m);
        hi_l += int'(motorL_pwm);
        hi_r += int'(motorR_pwm);
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic dl, input logic [7:0] ul, input logic dr_i, input logic [7:0] ur);
        cmd_dir_l = dl; cmd_duty_l = ul; cmd_dir_r = dr_i; cmd_duty_r = ur;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic measure(input string tag, input int exp_l, input int exp_r);
        hi_l = 0; hi_r = 0;
        run(PER);
        chk({tag, "_hi_l"}, hi_l, exp_l);
        chk({tag, "_hi_r"}, hi_r, exp_r);
    endtask

    initial begin
        int wait_n;
        // Power-up reset
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        run(3);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_settled", settled, 1);
        chk("rst_dir_l", motorL_dir, 1);
        reset = 1'b1;
        run(5);

        // Forward 128 on both wheels
        send(1'b1, 8'd128, 1'b1, 8'd128);
        run(600);
        measure("duty128", 128, 128);
        chk("settled128", settled, 1);

        // Left reversal from 200 to rev 100, right held at 200
        send(1'b1, 8'd200, 1'b1, 8'd200);
        run(800);
        send(1'b0, 8'd100, 1'b1, 8'd200);
        run(1300);
        measure("reverse", 100, 200);
        chk("rev_dir_l", motorL_dir, 0);
        chk("rev_dir_r", motorR_dir, 1);

        // Clear via stop, then retarget mid-ramp from about 64 down to 40
        stop_req = 1'b1;
        run(3);
        stop_req = 1'b0;
        send(1'b0, 8'd255, 1'b1, 8'd255);
        run(130);
        send(1'b0, 8'd40, 1'b1, 8'd40);
        run(800);
        measure("retarget40", 40, 40);

        // Full duty: one low cycle per period
        send(1'b0, 8'd255, 1'b1, 8'd255);
        run(1000);
        measure("duty255", 255, 255);

        // Emergency stop with a competing command
        stop_req = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir_l = 1'b1; cmd_duty_l = 8'd50;
        cmd_dir_r = 1'b0; cmd_duty_r = 8'd50;
        #1;
        chk("stop_pwm_l_now", motorL_pwm, 0);
        chk("stop_pwm_r_now", motorR_pwm, 0);
        chk("stop_ready_now", cmd_ready, 0);
        run(6);
        cmd_valid = 1'b0;
        stop_req = 1'b0;
        run(300);
        measure("after_stop", 0, 0);
        chk("stop_dir_l", motorL_dir, 0);
        chk("stop_dir_r", motorR_dir, 1);

        // Reset while the left wheel sits in dead time
        send(1'b1, 8'd255, 1'b1, 8'd255);
        run(10);
        chk("dead_ready", cmd_ready, 0);
        reset = 1'b0;
        run(2);
        chk("dead_rst_dir_l", motorL_dir, 1);
        chk("dead_rst_pwm_r", motorR_pwm, 0);
        reset = 1'b1;
        #1;
        chk("dead_rst_ready", cmd_ready, 1);
        run(4);

        // Random commands and stop pulses
        for (int it = 0; it < 60; it++) begin
            cmd_dir_l = 1'($urandom_range(0, 1));
            cmd_dir_r = 1'($urandom_range(0, 1));
            cmd_duty_l = 8'($urandom_range(0, 255));
            cmd_duty_r = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) cmd_duty_l = 8'd255;
            if ($urandom_range(0, 3) == 0) cmd_duty_r = 8'd0;
            cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            wait_n = $urandom_range(1, 500);
            if ($urandom_range(0, 7) == 0) begin
                run(wait_n / 2);
                stop_req = 1'b1;
                cmd_valid = 1'($urandom_range(0, 1));
                run($urandom_range(1, 20));
                stop_req = 1'b0;
                cmd_valid = 1'b0;
                run(wait_n / 2);
            end else begin
                run(wait_n);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
